// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle RV32 control unit: FETCH/DECODE/EXE/MEM/WB sequencing with sticky traps.
// Define MCU_MEM_TIMEOUT_EN to build the MEM wait-timeout counter.
//
// state  | meaning
// FETCH  | load instruction register
// DECODE | classify opcode, trap on undecoded
// EXE    | ALU/branch/jump complete here; loads/stores move on to MEM
// MEM    | hold data strobe until mem_ready
// WB     | load write-back
// TRAP   | sticky halt, left only by reset
module multi_cycle_control_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrCode,
  input  logic        btaken,
  input  logic        mem_ready,
  output logic        irWe,
  output logic        pcEn,
  output logic [1:0]  pcSrcMuxSel,
  output logic        regFileWe,
  output logic        aluSrcMuxSel,
  output logic        dataWe,
  output logic        dataRe,
  output logic [3:0]  aluControl,
  output logic [2:0]  RFWDSrcMuxSel,
  output logic        instRetired,
  output logic [2:0]  state_o,
  output logic        illegal,
  output logic        timeout
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXE    = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_L  = 7'b0000011;
  localparam logic [6:0] OP_S  = 7'b0100011;
  localparam logic [6:0] OP_B  = 7'b1100011;
  localparam logic [6:0] OP_LU = 7'b0110111;
  localparam logic [6:0] OP_AU = 7'b0010111;
  localparam logic [6:0] OP_J  = 7'b1101111;
  localparam logic [6:0] OP_JL = 7'b1100111;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255 || (1 << CNT_W) <= TIMEOUT_CYCLES) begin : g_bad_param
    $error("multi_cycle_control_unit: TIMEOUT_CYCLES/CNT_W out of range");
  end

  state_t     state;
  logic       illegal_q;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [3:0] op;
  logic       is_r, is_i, is_l, is_s, is_b, is_lu, is_au, is_j, is_jl;
  logic       legal;
  logic       unused_bits;

  assign opcode = instrCode[6:0];
  assign funct3 = instrCode[14:12];
  assign op     = {instrCode[30], funct3};
  assign unused_bits = ^{instrCode[31], instrCode[29:15], instrCode[11:7]};

  assign is_r  = (opcode == OP_R);
  assign is_i  = (opcode == OP_I);
  assign is_l  = (opcode == OP_L);
  assign is_s  = (opcode == OP_S);
  assign is_b  = (opcode == OP_B);
  assign is_lu = (opcode == OP_LU);
  assign is_au = (opcode == OP_AU);
  assign is_j  = (opcode == OP_J);
  assign is_jl = (opcode == OP_JL);
  assign legal = is_r | is_i | is_l | is_s | is_b | is_lu | is_au | is_j | is_jl;

`ifdef MCU_MEM_TIMEOUT_EN
  // Down-counter loaded on MEM entry; terminal count marks the last allowed wait cycle.
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_q;
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FETCH;
      illegal_q <= 1'b0;
`ifdef MCU_MEM_TIMEOUT_EN
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      case (state)
        FETCH: state <= DECODE;
        DECODE: begin
          if (legal) begin
            state <= EXE;
          end else begin
            state     <= TRAP;
            illegal_q <= 1'b1;
          end
        end
        EXE: begin
          if (is_s || is_l) begin
            state <= MEM;
`ifdef MCU_MEM_TIMEOUT_EN
            wait_cnt <= CNT_W'(TIMEOUT_CYCLES - 1);
`endif
          end else begin
            state <= FETCH;
          end
        end
        MEM: begin
          if (mem_ready) begin
            state <= is_l ? WB : FETCH;
`ifdef MCU_MEM_TIMEOUT_EN
            wait_cnt <= '0;
          end else if (wait_cnt == '0) begin
            state     <= TRAP;
            timeout_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
`endif
          end
        end
        WB:      state <= FETCH;
        TRAP:    state <= TRAP;
        default: state <= FETCH;
      endcase
    end
  end

  // Strobes are decoded from the current state so reset and mem_ready act within the cycle.
  always_comb begin
    irWe        = 1'b0;
    pcEn        = 1'b0;
    pcSrcMuxSel = 2'b00;
    regFileWe   = 1'b0;
    dataWe      = 1'b0;
    dataRe      = 1'b0;
    instRetired = 1'b0;
    if (!reset) begin
      case (state)
        FETCH: irWe = 1'b1;
        EXE: begin
          if (is_r || is_i || is_lu || is_au) begin
            regFileWe   = 1'b1;
            pcEn        = 1'b1;
            instRetired = 1'b1;
          end else if (is_b) begin
            pcEn        = 1'b1;
            pcSrcMuxSel = btaken ? 2'b01 : 2'b00;
            instRetired = 1'b1;
          end else if (is_j || is_jl) begin
            regFileWe   = 1'b1;
            pcEn        = 1'b1;
            pcSrcMuxSel = is_j ? 2'b01 : 2'b10;
            instRetired = 1'b1;
          end
        end
        MEM: begin
          if (is_s) begin
            dataWe = 1'b1;
            if (mem_ready) begin
              pcEn        = 1'b1;
              instRetired = 1'b1;
            end
          end else if (is_l) begin
            dataRe = 1'b1;
          end
        end
        WB: begin
          regFileWe   = 1'b1;
          pcEn        = 1'b1;
          instRetired = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    aluSrcMuxSel = is_i | is_l | is_s | is_jl;
    if (is_l)              RFWDSrcMuxSel = 3'b001;
    else if (is_lu)        RFWDSrcMuxSel = 3'b010;
    else if (is_au)        RFWDSrcMuxSel = 3'b011;
    else if (is_j | is_jl) RFWDSrcMuxSel = 3'b100;
    else                   RFWDSrcMuxSel = 3'b000;
    if (is_s || is_l || is_jl)           aluControl = 4'b0000;
    else if (is_i && (op != 4'b1101))    aluControl = {1'b0, funct3};
    else                                 aluControl = op;
  end

  assign state_o = state;
  assign illegal = illegal_q;

endmodule
